instr_encode_loader: RTL and testbench
======================================

Name: instr_encode_loader

Overview:
Generates MIPS instruction words, the encode direction of the single-cycle control decode. It accepts decoded instruction fields (operation class, register numbers, immediate) over a valid/ready handshake, assembles the 32-bit word and writes it sequentially into instruction memory through a write port. The program loader and test harness use it to fill imem before the core is released from reset.

Parameters:
ADDR_W, 8, word-address width of the imem write port
DEPTH, 256, number of words the loader may write (at most 2**ADDR_W)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous restart: pointer, count and error back to 0
in_valid  input  1  field bundle valid
in_ready  output  1  block can accept a bundle this cycle
op_sel  input  4  0 R-type, 1 lw, 2 sw, 3 addi, 4 j, 5 jal, 6 jr, 7 beq, 8 bne, 9-15 illegal
rs  input  5  source register
rt  input  5  target register
rd  input  5  destination register (R-type only)
shamt  input  5  shift amount (R-type only)
funct  input  6  function code (R-type only)
imm  input  26  low 16 bits for I-type; all 26 bits for j/jal target
imem_we  output  1  one-cycle write strobe
imem_addr  output  ADDR_W  word address of the write
imem_wdata  output  32  encoded instruction
count  output  ADDR_W+1  words written since reset or clear
full  output  1  count == DEPTH
err_illegal  output  1  sticky: illegal op_sel accepted

Behaviour:
- Reset (rst_n low, asynchronous): imem_we=0, imem_addr=0, imem_wdata=0, count=0, full=0, err_illegal=0, write pointer=0.
- in_ready = ~full & ~clear.
- Accept: in_valid & in_ready at a rising edge.
- Latency: exactly one cycle. The cycle after an accept drives imem_we=1, imem_addr=pointer and imem_wdata=encoded word. At the same edge that registers the output, pointer and count increment.
- Throughput: one bundle per cycle. Back-to-back accepts give consecutive addresses with imem_we held high.
- Encoding, fields packed MSB first:
  - R-type: op 0x00, rs, rt, rd, shamt, funct.
  - lw: op 0x23, rs, rt, imm[15:0].
  - sw: op 0x2B, rs, rt, imm[15:0].
  - addi: op 0x08, rs, rt, imm[15:0].
  - beq: op 0x04, rs, rt, imm[15:0].
  - bne: op 0x05, rs, rt, imm[15:0].
  - j: op 0x02, imm[25:0].
  - jal: op 0x03, imm[25:0].
  - jr: op 0x00, rs, then zeros in rt/rd/shamt, funct 0x08.
  - Unused inputs are ignored.
- Illegal op_sel (9-15): the handshake completes, no write occurs (imem_we=0 next cycle), pointer and count are unchanged, and err_illegal is set. err_illegal clears only on reset or clear.
- Full: when count reaches DEPTH, full=1 and in_ready=0, so no further accepts. The pointer never wraps. The final write (address DEPTH-1) still issues normally.
- clear high: no accept that cycle. Next cycle: pointer=0, count=0, full=0, err_illegal=0, imem_we=0. A write already registered from the previous cycle's accept is still driven in the clear cycle.
- Reset mid-stream: the pending write is dropped immediately and all state returns to reset values.
- in_valid with in_ready low: no state change. The bundle must be held by the source.

Test Plan:
- Reset then op_sel=1, rs=16, rt=8, imm=4 -> next cycle imem_we=1, addr=0, wdata=0x8E080004; count=1.
- Back-to-back bundles:
  - R-type rs=1, rt=2, rd=3, shamt=0, funct=0x20 -> 0x00221820 @0.
  - jal imm=0x0100000 -> 0x0C100000 @1.
  - jr rs=31 -> 0x03E00008 @2.
  - imem_we high for 3 consecutive cycles.
- beq rs=1, rt=2, imm=0x3FFFFFF -> 0x1022FFFF; op_sel=12 -> no write, err_illegal=1, count unchanged; the next legal bundle lands at the unchanged address.
- DEPTH=4: send 5 bundles with in_valid held -> 4 writes at addr 0-3, full=1, in_ready=0, fifth bundle never accepted.
- clear pulse after 3 writes -> count=0, err_illegal=0; the next write lands at addr 0.
- rst_n low in the cycle after an accept -> imem_we drops asynchronously; all outputs equal reset values.

Source files
------------

// File: rtl/instr_encode_loader.sv
// Encodes decoded MIPS instruction fields into 32-bit words and streams them
// into consecutive instruction-memory addresses through a registered write port.
module instr_encode_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [25:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_illegal
);

  // Handshake: a bundle transfers on a rising edge where in_valid and in_ready
  // are both high; while in_ready is low the source holds the bundle unchanged.

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_LW    = 4'd1;
  localparam logic [3:0] OP_SW    = 4'd2;
  localparam logic [3:0] OP_ADDI  = 4'd3;
  localparam logic [3:0] OP_J     = 4'd4;
  localparam logic [3:0] OP_JAL   = 4'd5;
  localparam logic [3:0] OP_JR    = 4'd6;
  localparam logic [3:0] OP_BEQ   = 4'd7;
  localparam logic [3:0] OP_BNE   = 4'd8;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_count;
  logic              r_err;

  logic              w_full;
  logic              w_ready;
  logic              w_accept;
  logic              w_legal;
  logic [31:0]       w_enc;
  logic [ADDR_W-1:0] w_ptr;

  assign w_full   = (r_count == LP_DEPTH);
  assign w_ready  = ~w_full & ~clear;
  assign w_accept = in_valid & w_ready;
  // The pointer always equals the number of words written; full blocks wrap.
  assign w_ptr    = r_count[ADDR_W-1:0];

  always_comb begin
    w_enc   = 32'h0;
    w_legal = 1'b1;
    case (op_sel)
      OP_RTYPE: w_enc = {6'h00, rs, rt, rd, shamt, funct};
      OP_LW:    w_enc = {6'h23, rs, rt, imm[15:0]};
      OP_SW:    w_enc = {6'h2B, rs, rt, imm[15:0]};
      OP_ADDI:  w_enc = {6'h08, rs, rt, imm[15:0]};
      OP_J:     w_enc = {6'h02, imm};
      OP_JAL:   w_enc = {6'h03, imm};
      OP_JR:    w_enc = {6'h00, rs, 15'h0, 6'h08};
      OP_BEQ:   w_enc = {6'h04, rs, rt, imm[15:0]};
      OP_BNE:   w_enc = {6'h05, rs, rt, imm[15:0]};
      default:  w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (clear) begin
      r_we    <= 1'b0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_we <= w_accept & w_legal;
      if (w_accept & w_legal) begin
        r_addr  <= w_ptr;
        r_wdata <= w_enc;
        r_count <= r_count + LP_ONE;
      end
      // Illegal selects still complete the handshake but only flag the error.
      if (w_accept & ~w_legal) begin
        r_err <= 1'b1;
      end
    end
  end

  assign in_ready    = w_ready;
  assign imem_we     = r_we;
  assign imem_addr   = r_addr;
  assign imem_wdata  = r_wdata;
  assign count       = r_count;
  assign full        = w_full;
  assign err_illegal = r_err;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader with DEPTH=4 so the full boundary is reachable.
module tb_instr_encode_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op_sel;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [25:0]       imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err_illegal;

  int errors = 0;
  int checks = 0;

  instr_encode_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_sel     (op_sel),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .shamt      (shamt),
    .funct      (funct),
    .imm        (imm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .full       (full),
    .err_illegal(err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge and settle so registered outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
                       input logic [25:0] im);
    in_valid = 1'b1;
    op_sel   = o;
    rs       = s;
    rt       = t;
    rd       = d;
    shamt    = sh;
    funct    = fn;
    imm      = im;
  endtask

  task automatic do_clear();
    in_valid = 1'b0;
    clear    = 1'b1;
    step();
    clear    = 1'b0;
  endtask

  logic [3:0]  full_op  [5];
  logic [31:0] full_exp [4];

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
    op_sel = '0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0; imm = '0;
    full_op  = '{4'd2, 4'd8, 4'd4, 4'd3, 4'd1};
    full_exp = '{32'hAC45FFFC, 32'h14801234, 32'h0BFFFFFF, 32'h20640010};
    repeat (2) step();

    chk("rst_we",    32'(imem_we),     32'd0);
    chk("rst_addr",  32'(imem_addr),   32'd0);
    chk("rst_wdata", imem_wdata,       32'd0);
    chk("rst_count", 32'(count),       32'd0);
    chk("rst_full",  32'(full),        32'd0);
    chk("rst_err",   32'(err_illegal), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_ready", 32'(in_ready), 32'd1);

    // Single lw
    drive(4'd1, 5'd16, 5'd8, 5'd0, 5'd0, 6'd0, 26'd4);
    step();
    in_valid = 1'b0;
    chk("lw_we",    32'(imem_we),   32'd1);
    chk("lw_addr",  32'(imem_addr), 32'd0);
    chk("lw_wdata", imem_wdata,     32'h8E080004);
    chk("lw_count", 32'(count),     32'd1);
    step();
    chk("lw_we_drop", 32'(imem_we), 32'd0);

    do_clear();
    chk("clr1_count", 32'(count), 32'd0);

    // Back-to-back R-type, jal, jr; unused fields carry junk that must be ignored
    drive(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 26'h3FFFFFF);
    step();
    chk("bb0_we",    32'(imem_we),   32'd1);
    chk("bb0_addr",  32'(imem_addr), 32'd0);
    chk("bb0_wdata", imem_wdata,     32'h00221820);
    drive(4'd5, 5'd7, 5'd9, 5'd11, 5'd13, 6'h3F, 26'h0100000);
    step();
    chk("bb1_we",    32'(imem_we),   32'd1);
    chk("bb1_addr",  32'(imem_addr), 32'd1);
    chk("bb1_wdata", imem_wdata,     32'h0C100000);
    drive(4'd6, 5'd31, 5'd5, 5'd6, 5'd7, 6'h3F, 26'h3FFFFFF);
    step();
    in_valid = 1'b0;
    chk("bb2_we",    32'(imem_we),   32'd1);
    chk("bb2_addr",  32'(imem_addr), 32'd2);
    chk("bb2_wdata", imem_wdata,     32'h03E00008);
    chk("bb_count",  32'(count),     32'd3);
    step();
    chk("bb_we_drop", 32'(imem_we), 32'd0);

    // Illegal after 3 writes, then clear restores everything
    drive(4'd12, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 26'd1);
    chk("ill_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("ill_we",    32'(imem_we),     32'd0);
    chk("ill_err",   32'(err_illegal), 32'd1);
    chk("ill_count", 32'(count),       32'd3);
    step();
    chk("ill_sticky", 32'(err_illegal), 32'd1);
    do_clear();
    chk("clr2_count", 32'(count),       32'd0);
    chk("clr2_err",   32'(err_illegal), 32'd0);
    chk("clr2_full",  32'(full),        32'd0);

    // beq with oversized imm, illegal, then addi lands at unchanged address
    drive(4'd7, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 26'h3FFFFFF);
    step();
    chk("beq_addr",  32'(imem_addr), 32'd0);
    chk("beq_wdata", imem_wdata,     32'h1022FFFF);
    drive(4'd12, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 26'd0);
    step();
    chk("ill2_we",    32'(imem_we),     32'd0);
    chk("ill2_err",   32'(err_illegal), 32'd1);
    chk("ill2_count", 32'(count),       32'd1);
    drive(4'd3, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 26'h0000010);
    step();
    in_valid = 1'b0;
    chk("addi_we",    32'(imem_we),   32'd1);
    chk("addi_addr",  32'(imem_addr), 32'd1);
    chk("addi_wdata", imem_wdata,     32'h20640010);
    chk("addi_count", 32'(count),     32'd2);

    // Fill to DEPTH with in_valid held; the fifth bundle must stall
    do_clear();
    for (int i = 0; i < 5; i++) begin
      case (full_op[i])
        4'd2:    drive(4'd2, 5'd2, 5'd5, 5'd0, 5'd0, 6'd0, 26'h000FFFC);
        4'd8:    drive(4'd8, 5'd4, 5'd0, 5'd0, 5'd0, 6'd0, 26'h0001234);
        4'd4:    drive(4'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 26'h3FFFFFF);
        4'd3:    drive(4'd3, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 26'h0000010);
        default: drive(4'd1, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 26'd5);
      endcase
      step();
      if (i < 4) begin
        chk($sformatf("full%0d_we", i),    32'(imem_we),   32'd1);
        chk($sformatf("full%0d_addr", i),  32'(imem_addr), 32'(i));
        chk($sformatf("full%0d_wdata", i), imem_wdata,     full_exp[i]);
      end else begin
        chk("full_stall_we", 32'(imem_we), 32'd0);
      end
    end
    chk("full_count", 32'(count),    32'd4);
    chk("full_flag",  32'(full),     32'd1);
    chk("full_ready", 32'(in_ready), 32'd0);
    step();
    chk("full_hold_count", 32'(count),   32'd4);
    chk("full_hold_we",    32'(imem_we), 32'd0);
    in_valid = 1'b0;

    // Write registered before clear is still presented during the clear cycle
    do_clear();
    drive(4'd1, 5'd16, 5'd8, 5'd0, 5'd0, 6'd0, 26'd4);
    step();
    in_valid = 1'b0;
    clear = 1'b1;
    #1;
    chk("clr_cycle_we",    32'(imem_we),  32'd1);
    chk("clr_cycle_ready", 32'(in_ready), 32'd0);
    step();
    clear = 1'b0;
    chk("clr3_we",    32'(imem_we), 32'd0);
    chk("clr3_count", 32'(count),   32'd0);
    drive(4'd3, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 26'h0000010);
    step();
    in_valid = 1'b0;
    chk("clr3_addr", 32'(imem_addr), 32'd0);

    // Asynchronous reset while a write is being driven
    drive(4'd1, 5'd16, 5'd8, 5'd0, 5'd0, 6'd0, 26'd4);
    step();
    in_valid = 1'b0;
    chk("pre_rst_we", 32'(imem_we), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we",    32'(imem_we),     32'd0);
    chk("arst_addr",  32'(imem_addr),   32'd0);
    chk("arst_wdata", imem_wdata,       32'd0);
    chk("arst_count", 32'(count),       32'd0);
    chk("arst_full",  32'(full),        32'd0);
    chk("arst_err",   32'(err_illegal), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
